mem_stage: RTL and testbench

- Memory-access stage directly downstream of the EXE/MEM pipeline register.
- Consumes IR/PC/Z/Addr and performs load/store via a req/ack data-memory handshake.
- Stalls upstream while an access is outstanding; produces registered IR/PC/result for the MEM/WB path.
- Non-memory instructions pass through in one cycle.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and types for the memory-access stage.
//   - DEF_WIDTH      default datapath width
//   - OP_W           opcode field width (field sits in IR[WIDTH-1 -: OP_W])
//   - OP_LOAD/STORE  memory opcodes; OP_ADD is a representative non-memory op
//   - CNT_W          timeout counter width (MEM_TIMEOUT is at most 255)
//   - mem_state_e    FSM state encoding
package mem_stage_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int OP_W      = 6;
  localparam int CNT_W     = 8;

  localparam logic [OP_W-1:0] OP_ADD   = 6'h00;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'h23;
  localparam logic [OP_W-1:0] OP_STORE = 6'h2B;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/acknowledge bus.
//   master (stage side) : drives dmem_req, dmem_we, dmem_addr, dmem_wdata
//   slave  (memory side): drives dmem_ack, dmem_rdata
//
// Handshake: the master raises dmem_req with we/addr/wdata and holds all four
// stable until it sees dmem_ack high on a rising edge (or gives up after a
// timeout). The slave raises dmem_ack for exactly the cycle in which the
// access completes; for a load dmem_rdata is valid in that same cycle. An ack
// seen while dmem_req is low carries no meaning and is ignored. The master may
// withdraw dmem_req without an ack only on timeout or reset.
interface mem_stage_if #(
  parameter int WIDTH = 32
);
  logic             dmem_req;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic             dmem_ack;
  logic [WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage downstream of the EXE/MEM register.
// Non-memory instructions pass through with one cycle of latency. Loads and
// stores issue a request on the dmem bus and stall upstream until the memory
// acknowledges or MEM_TIMEOUT cycles elapse (sticky mem_err on timeout).
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   valid_in, IR_in,   instruction from EXE/MEM (held by upstream while
//   PC_in, Z_in,       stall_out is high)
//   Addr_in
//   stall_out          combinational upstream hold request
//   dmem               data-memory bus (master side)
//   valid_out, IR_out, registered MEM/WB outputs; Z_out carries load data,
//   PC_out, Z_out      store data / ALU result, or 0 after a timeout
//   mem_err            sticky timeout flag, cleared only by reset
//   state_dbg          current FSM state
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] Addr_in,
  output logic             stall_out,
  mem_stage_if.master      dmem,
  output logic             valid_out,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] Z_out,
  output logic             mem_err,
  output mem_state_e       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-3:0] pc_q, pc_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             err_q, err_d;

  logic [OP_W-1:0]  op;
  logic             is_load, is_store, is_mem;
  logic             in_wait, timeout_hit;

  assign op       = IR_in[WIDTH-1 -: OP_W];
  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  assign is_mem   = is_load | is_store;

  assign in_wait     = (state_q == MEM_WAIT);
  // Ack on the boundary cycle takes priority over the timeout.
  assign timeout_hit = in_wait & (cnt_q == CNT_LAST) & ~dmem.dmem_ack;

  // Gated by rst_n so upstream sees no stall while the stage is held in reset.
  assign stall_out = rst_n &
                     (((state_q == MEM_IDLE) & valid_in & is_mem) |
                      (in_wait & ~dmem.dmem_ack & ~timeout_hit));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    ir_d    = ir_q;
    pc_d    = pc_q;
    z_d     = z_q;
    err_d   = err_q;

    unique case (state_q)
      MEM_IDLE: begin
        if (valid_in) begin
          if (is_mem) begin
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = Addr_in;
            wdata_d = Z_in;
            cnt_d   = '0;
            state_d = MEM_WAIT;
          end else begin
            ir_d    = IR_in;
            pc_d    = PC_in;
            z_d     = Z_in;
            valid_d = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        // IR/PC/Z inputs are still those of the stalled instruction here.
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          ir_d    = IR_in;
          pc_d    = PC_in;
          z_d     = is_load ? dmem.dmem_rdata : Z_in;
          valid_d = 1'b1;
          state_d = MEM_IDLE;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          ir_d    = IR_in;
          pc_d    = PC_in;
          z_d     = '0;
          valid_d = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign valid_out       = valid_q;
  assign IR_out          = ir_q;
  assign PC_out          = pc_q;
  assign Z_out           = z_q;
  assign mem_err         = err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int WIDTH = 32;
  localparam int TO    = 4;
  localparam int W     = WIDTH + (WIDTH - 2) + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             valid_in;
  logic [WIDTH-1:0] IR_in, Z_in, Addr_in;
  logic [WIDTH-3:0] PC_in;
  logic             stall_out, valid_out, mem_err;
  logic [WIDTH-1:0] IR_out, Z_out;
  logic [WIDTH-3:0] PC_out;
  mem_state_e       state_dbg;

  mem_stage_if #(.WIDTH(WIDTH)) dmem ();

  mem_stage #(.WIDTH(WIDTH), .MEM_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .IR_in     (IR_in),
    .PC_in     (PC_in),
    .Z_in      (Z_in),
    .Addr_in   (Addr_in),
    .stall_out (stall_out),
    .dmem      (dmem.master),
    .valid_out (valid_out),
    .IR_out    (IR_out),
    .PC_out    (PC_out),
    .Z_out     (Z_out),
    .mem_err   (mem_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic         exp_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor: every valid_out pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (exp_q.size() == 0) check_eq("spurious_valid", 96'(valid_out), 96'd0);
      else check_eq("out_ir_pc_z", 96'({IR_out, PC_out, Z_out}), 96'(exp_q.pop_front()));
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after a falling edge with
  // the stage back in IDLE.
  task automatic issue_op(input logic [WIDTH-1:0] ir, input logic [WIDTH-3:0] pc,
                          input logic [WIDTH-1:0] z, input logic [WIDTH-1:0] addr,
                          input int ack_dly, input logic [WIDTH-1:0] rdata);
    logic [OP_W-1:0] op;
    logic            ld, st, mem, ack, done;
    op  = ir[WIDTH-1 -: OP_W];
    ld  = (op == OP_LOAD);
    st  = (op == OP_STORE);
    mem = ld | st;
    valid_in = 1'b1; IR_in = ir; PC_in = pc; Z_in = z; Addr_in = addr;
    #1;
    check_eq("stall_issue", 96'(stall_out), 96'(mem));
    if (!mem) begin
      exp_q.push_back({ir, pc, z});
      @(negedge clk);
      valid_in = 1'b0;
      check_eq("valid_lat_alu", 96'(valid_out), 96'd1);
    end else begin
      check_eq("req_idle", 96'(dmem.dmem_req), 96'd0);
      @(negedge clk);
      done = 1'b0;
      for (int i = 0; i < TO && !done; i++) begin
        check_eq("req_wait", 96'(dmem.dmem_req), 96'd1);
        check_eq("we", 96'(dmem.dmem_we), 96'(st));
        check_eq("addr", 96'(dmem.dmem_addr), 96'(addr));
        if (st) check_eq("wdata", 96'(dmem.dmem_wdata), 96'(z));
        ack = (ack_dly == i);
        dmem.dmem_ack   = ack;
        dmem.dmem_rdata = ack ? rdata : $urandom;
        if (ack) begin
          exp_q.push_back({ir, pc, (ld ? rdata : z)});
          done = 1'b1;
        end else if (i == TO - 1) begin
          exp_q.push_back({ir, pc, {WIDTH{1'b0}}});
          exp_err = 1'b1;
          done = 1'b1;
        end
        #1;
        check_eq("stall_wait", 96'(stall_out), 96'(!done));
        @(negedge clk);
      end
      dmem.dmem_ack = 1'b0;
      valid_in = 1'b0;
      check_eq("req_after", 96'(dmem.dmem_req), 96'd0);
      check_eq("valid_lat_mem", 96'(valid_out), 96'd1);
    end
    check_eq("mem_err", 96'(mem_err), 96'(exp_err));
  endtask

  function automatic logic [WIDTH-1:0] mk_ir(input logic [OP_W-1:0] op);
    logic [WIDTH-OP_W-1:0] rest;
    rest = WIDTH'($urandom);
    return {op, rest};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; valid_in = 1'b0; IR_in = '0; PC_in = '0; Z_in = '0; Addr_in = '0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", 96'(dmem.dmem_req), 96'd0);
    check_eq("rst_valid", 96'(valid_out), 96'd0);
    check_eq("rst_err", 96'(mem_err), 96'd0);
    check_eq("rst_outs", 96'({IR_out, PC_out, Z_out}), 96'd0);
    check_eq("rst_state", 96'(state_dbg), 96'(MEM_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Non-memory pass-through, then back-to-back ALU op.
    issue_op(mk_ir(OP_ADD), 30'h100, 32'h0000_1234, 32'h0, 0, 32'h0);
    issue_op(mk_ir(OP_ADD), 30'h101, 32'h5555_AAAA, 32'h0, 0, 32'h0);
    // Load, ack after two wait cycles.
    issue_op(mk_ir(OP_LOAD), 30'h102, 32'h0, 32'h40, 2, 32'hDEAD_BEEF);
    // Store, zero-wait ack, directly back-to-back.
    issue_op(mk_ir(OP_STORE), 30'h103, 32'hCAFE_0001, 32'h80, 0, 32'h1111_2222);
    // Ack exactly on the last WAIT cycle: normal completion.
    issue_op(mk_ir(OP_LOAD), 30'h104, 32'h0, 32'hC0, TO - 1, 32'h0BAD_F00D);
    // Load with no ack: timeout.
    issue_op(mk_ir(OP_LOAD), 30'h105, 32'h0, 32'h44, TO + 10, 32'h0);

    // Late ack in IDLE: no output change, error stays.
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem.dmem_ack = 1'b0;
    check_eq("late_valid", 96'(valid_out), 96'd0);
    check_eq("late_z", 96'(Z_out), 96'd0);
    check_eq("late_err", 96'(mem_err), 96'd1);
    check_eq("late_req", 96'(dmem.dmem_req), 96'd0);
    @(negedge clk);
    check_eq("err_sticky", 96'(mem_err), 96'd1);

    // Reset in the middle of a WAIT.
    valid_in = 1'b1; IR_in = mk_ir(OP_LOAD); PC_in = 30'h106; Z_in = '0; Addr_in = 32'h48;
    @(negedge clk);
    @(negedge clk);
    check_eq("midwait_state", 96'(state_dbg), 96'(MEM_WAIT));
    check_eq("midwait_req", 96'(dmem.dmem_req), 96'd1);
    rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    check_eq("rst_mid_req", 96'(dmem.dmem_req), 96'd0);
    check_eq("rst_mid_valid", 96'(valid_out), 96'd0);
    check_eq("rst_mid_stall", 96'(stall_out), 96'd0);
    check_eq("rst_mid_err", 96'(mem_err), 96'd0);
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_op(mk_ir(OP_LOAD), 30'h107, 32'h0, 32'h48, 1, 32'h1234_5678);

    // Random mix, acks always inside the timeout window.
    for (int n = 0; n < 12; n++) begin
      logic [OP_W-1:0] op;
      case ($urandom_range(0, 2))
        0: op = OP_ADD;
        1: op = OP_LOAD;
        default: op = OP_STORE;
      endcase
      issue_op(mk_ir(op), 30'($urandom), $urandom, $urandom,
               int'($urandom_range(0, TO - 1)), $urandom);
    end

    @(negedge clk);
    check_eq("queue_drained", 96'(exp_q.size()), 96'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
